// File: rtl/pipeline_hs.sv
// pipeline_hs: three-stage valid/ready pipeline computing
//   F   = ((A+B)*C - D) mod 2^N
//   ovf = exact difference lies outside 0..2^N-1
// Stage 1 holds A+B, C and D. Stage 2 holds (A+B)*C and D. Stage 3 holds F and ovf.
// Each stage has a valid bit. A stage may load when it is empty or when the
// stage below it is advancing. Because of this, in_ready follows out_ready
// combinationally, and a full pipeline keeps one-per-cycle throughput.

module pipeline_hs #(
   parameter int N = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [N-1:0] C,
   input  logic [N-1:0] D,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] F,
   output logic         ovf,
   output logic         out_valid,
   input  logic         out_ready
);

   // Exact intermediate widths: sum N+1, product 2N+1, signed difference 2N+2.
   localparam int SW = N + 1;
   localparam int PW = 2 * N + 1;
   localparam int DW = 2 * N + 2;

   // Exact difference of the product and D, in two's complement over DW bits.
   function automatic logic [DW-1:0] diff_of(input logic [PW-1:0] p, input logic [N-1:0] d);
      logic [DW-1:0] pe;
      logic [DW-1:0] de;
      pe = {1'b0, p};
      de = {{(DW-N){1'b0}}, d};
      return pe - de;
   endfunction

   // Out of range when the difference is negative or needs more than N bits.
   function automatic logic range_err(input logic [DW-1:0] x);
      return x[DW-1] | (|x[DW-2:N]);
   endfunction

   // Stage valid bits.
   logic          v1_r;
   logic          v2_r;
   logic          v3_r;

   // Stage data registers.
   logic [SW-1:0] sum1_r;
   logic [N-1:0]  c1_r;
   logic [N-1:0]  d1_r;
   logic [PW-1:0] prod2_r;
   logic [N-1:0]  d2_r;
   logic [N-1:0]  f3_r;
   logic          ovf3_r;

   // Advance enables and combinational datapath values.
   logic          adv1_s;
   logic          adv2_s;
   logic          adv3_s;
   logic [SW-1:0] sum_s;
   logic [PW-1:0] prod_s;
   logic [DW-1:0] diff_s;

   // Stall chain. A stage advances when it is empty or the stage below advances.
   always_comb begin
      adv3_s = 1'b0;
      adv2_s = 1'b0;
      adv1_s = 1'b0;
      adv3_s = (~v3_r) | out_ready;
      adv2_s = (~v2_r) | adv3_s;
      adv1_s = (~v1_r) | adv2_s;
   end

   // Arithmetic for each stage, widened so that no carry or sign is lost.
   always_comb begin
      sum_s  = {SW{1'b0}};
      prod_s = {PW{1'b0}};
      diff_s = {DW{1'b0}};
      sum_s  = {1'b0, A} + {1'b0, B};
      prod_s = {{(PW-SW){1'b0}}, sum1_r} * {{(PW-N){1'b0}}, c1_r};
      diff_s = diff_of(prod2_r, d2_r);
   end

   // Stage 1: capture the operand sum, C and D when the stage advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r   <= 1'b0;
         sum1_r <= {SW{1'b0}};
         c1_r   <= {N{1'b0}};
         d1_r   <= {N{1'b0}};
      end else if (adv1_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            sum1_r <= sum_s;
            c1_r   <= C;
            d1_r   <= D;
         end
      end
   end

   // Stage 2: capture the product and carry D forward when the stage advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r    <= 1'b0;
         prod2_r <= {PW{1'b0}};
         d2_r    <= {N{1'b0}};
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            prod2_r <= prod_s;
            d2_r    <= d1_r;
         end
      end
   end

   // Stage 3: the result registers. They change only when a valid set arrives,
   // so F stays stable while it is held under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_r   <= 1'b0;
         f3_r   <= {N{1'b0}};
         ovf3_r <= 1'b0;
      end else if (adv3_s) begin
         v3_r <= v2_r;
         if (v2_r) begin
            f3_r   <= diff_s[N-1:0];
            ovf3_r <= range_err(diff_s);
         end
      end
   end

   assign in_ready  = adv1_s;
   assign out_valid = v3_r;
   assign F         = f3_r;
   assign ovf       = ovf3_r;

endmodule

// File: tb/tb_pipeline_hs.sv
// Self-checking bench for pipeline_hs.
// The driver pushes the hand-computed {F,ovf} onto a queue whenever a set is accepted.
// A separate monitor pops that queue on each output transfer and compares the result.
// The monitor also checks that F and ovf stay stable while the output is stalled.
module tb_pipeline_hs;
   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] c = '0;
   logic [N-1:0] d = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] f;
   logic         ovf;
   logic         out_valid;
   logic         out_ready = 1'b1;

   int checks = 0;
   int errors = 0;
   int pops = 0;
   logic [N:0] exp_q[$];

   pipeline_hs #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d),
      .in_valid(in_valid), .in_ready(in_ready), .F(f), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Present one set and hold it until the DUT accepts it (bounded).
   task automatic send(input int va, input int vb, input int vc, input int vd,
                       input int ef, input int eo);
      logic done;
      logic [N:0] e;
      done = 1'b0;
      a = va[N-1:0]; b = vb[N-1:0]; c = vc[N-1:0]; d = vd[N-1:0];
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (!done) begin
            @(negedge clk);
            if (in_ready) begin
               e = {ef[N-1:0], eo[0]};
               exp_q.push_back(e);
               done = 1'b1;
            end
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      if (!done) chk("send_accept_timeout", 0, 1);
   endtask

   // Wait until every expected result has been seen (bounded).
   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: compare each output transfer against the scoreboard, and check hold stability.
   initial begin
      logic       prev_hold;
      logic [N-1:0] prev_f;
      logic       prev_ovf;
      logic [N:0] e;
      prev_hold = 1'b0;
      prev_f = '0;
      prev_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_F", f, prev_f);
               chk("hold_ovf", ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result F=%0d ovf=%0d expected=none", f, ovf);
               end else begin
                  e = exp_q.pop_front();
                  chk("result_F", f, e[N:1]);
                  chk("result_ovf", ovf, e[0]);
                  pops++;
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_f = f;
            prev_ovf = ovf;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int idx;
      int ta[4];
      int tb_[4];
      int tc[4];
      int td[4];
      int tf[4];
      ta = '{1, 5, 2, 3}; tb_ = '{2, 6, 2, 4}; tc = '{3, 7, 2, 5}; td = '{4, 8, 2, 6};
      tf = '{5, 69, 6, 29};

      // Reset state.
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_F", f, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("first_edge_ready", in_ready, 1);

      // Single set and latency: result visible after the third edge from acceptance.
      send(10, 12, 6, 3, 129, 0);
      @(negedge clk); chk("latency_edge1", out_valid, 0);
      @(negedge clk); chk("latency_edge2", out_valid, 0);
      @(negedge clk); chk("latency_edge3", out_valid, 1);
      drain();

      // Back-to-back: three results on three consecutive cycles.
      send(10, 12, 6, 3, 129, 0);
      send(10, 10, 5, 3, 97, 0);
      send(20, 11, 1, 4, 27, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b2b_valid", out_valid, 1);
      end
      @(negedge clk);
      chk("b2b_gap_after", out_valid, 0);
      drain();

      // Backpressure: out_ready low for 6 cycles, 4 sets offered, only 3 accepted.
      out_ready = 1'b0;
      acc = 0;
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         a = ta[idx][N-1:0]; b = tb_[idx][N-1:0]; c = tc[idx][N-1:0]; d = td[idx][N-1:0];
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back({tf[idx][N-1:0], 1'b0});
            acc++;
            if (idx < 3) idx++;
         end
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", acc, 3);
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_F_held", f, 5);
      out_ready = 1'b1;
      send(ta[3], tb_[3], tc[3], td[3], tf[3], 0);
      drain();

      // Overflow, underflow and range boundaries.
      send(1023, 1023, 1023, 0, 2, 1);
      send(0, 0, 5, 7, 1017, 1);
      send(0, 0, 0, 0, 0, 0);
      send(1023, 0, 1, 0, 1023, 0);
      send(0, 0, 0, 1, 1023, 1);
      drain();

      // Reset with two sets in flight, one already at the output.
      out_ready = 1'b0;
      send(1, 1, 1, 1, 1, 0);
      send(2, 2, 2, 2, 6, 0);
      @(posedge clk);
      #1;
      chk("pre_reset_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", out_valid, 0);
      chk("mid_reset_F", f, 0);
      chk("mid_reset_ovf", ovf, 0);
      chk("mid_reset_in_ready", in_ready, 1);
      exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_reset_idle", out_valid, 0);
      send(7, 1, 2, 3, 13, 0);
      drain();

      chk("total_results", pops, 14);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
